// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment bank driver: double-buffered BCD/dp/blank data,
// one digit per slot with a leading all-off guard window to avoid ghosting.
module seg7_mux_driver #(
   parameter int NUM_DIGITS  = 6,
   parameter int REFRESH_DIV = 1000,
   parameter int GUARD       = 2
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_load,
   input  logic [4*NUM_DIGITS-1:0] i_bcd,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   output logic [6:0]              o_led,
   output logic                    o_dp,
   output logic [NUM_DIGITS-1:0]   o_digit_sel,
   output logic                    o_frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
   localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DRIVE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DW-1:0]           dig_q, dig_d;
   logic                    frame_start;

   logic [4*NUM_DIGITS-1:0] pend_bcd_q, act_bcd_q, act_bcd_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q, act_blank_d;

   logic [6:0]              led_q, led_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic                    fd_q, fd_d;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'b1111110;
         4'd1:    seg_decode = 7'b0110000;
         4'd2:    seg_decode = 7'b1101101;
         4'd3:    seg_decode = 7'b1111001;
         4'd4:    seg_decode = 7'b0110011;
         4'd5:    seg_decode = 7'b1011011;
         4'd6:    seg_decode = 7'b1011111;
         4'd7:    seg_decode = 7'b1110000;
         4'd8:    seg_decode = 7'b1111111;
         4'd9:    seg_decode = 7'b1111011;
         default: seg_decode = 7'b0000000;
      endcase
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
      end
   end

   // Guard/drive phase is a pure function of the position within the slot.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dig_d       = dig_q;
      frame_start = 1'b0;
      if (!i_enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         dig_d   = '0;
      end else if (state_q == S_IDLE) begin
         cnt_d       = '0;
         dig_d       = '0;
         frame_start = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (dig_q == DIG_LAST) begin
            dig_d       = '0;
            frame_start = 1'b1;
         end else begin
            dig_d = dig_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      if (i_enable)
         state_d = (cnt_d < GUARD_C) ? S_GUARD : S_DRIVE;
   end

   assign act_bcd_d   = frame_start ? pend_bcd_q   : act_bcd_q;
   assign act_dp_d    = frame_start ? pend_dp_q    : act_dp_q;
   assign act_blank_d = frame_start ? pend_blank_q : act_blank_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pend_bcd_q   <= '1;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         act_bcd_q    <= '1;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
      end else begin
         if (i_load) begin
            pend_bcd_q   <= i_bcd;
            pend_dp_q    <= i_dp;
            pend_blank_q <= i_blank;
         end
         act_bcd_q   <= act_bcd_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
      end
   end

   // Outputs are computed from next-state so they register in step with it.
   always_comb begin
      led_d = '0;
      dp_d  = 1'b0;
      sel_d = '0;
      fd_d  = 1'b0;
      if (state_d == S_DRIVE) begin
         sel_d[dig_d] = 1'b1;
         if (!act_blank_d[dig_d]) begin
            led_d = seg_decode(act_bcd_d[{dig_d, 2'b00} +: 4]);
            dp_d  = act_dp_d[dig_d];
         end
      end
      if (state_d != S_IDLE && cnt_d == CNT_LAST && dig_d == DIG_LAST)
         fd_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         led_q <= '0;
         dp_q  <= 1'b0;
         sel_q <= '0;
         fd_q  <= 1'b0;
      end else begin
         led_q <= led_d;
         dp_q  <= dp_d;
         sel_q <= sel_d;
         fd_q  <= fd_d;
      end
   end

   assign o_led        = led_q;
   assign o_dp         = dp_q;
   assign o_digit_sel  = sel_q;
   assign o_frame_done = fd_q;

endmodule

// File: doc/seg7_mux_driver.md
# seg7_mux_driver

Time-multiplexed driver for a common-segment 7-segment display bank. Latches a packed BCD word, decimal-point mask and blank mask on a load strobe, then scans one digit at a time, driving the active-high segment pattern and a one-hot digit select. It sits directly upstream of the segment-to-BCD checker used in the testbench: `o_led` uses the same a..g bit order, so the bench can decode it back to digit values.

## Interface
- `NUM_DIGITS`, default 6: number of digits scanned; 1 to 8.
- `REFRESH_DIV`, default 1000: clock cycles per digit slot; at least 2.
- `GUARD`, default 2: anti-ghosting cycles at the start of each slot with everything off; 0 to `REFRESH_DIV`-1.
- `i_clk`  in  1: sole clock; all logic on its rising edge.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_enable`  in  1: scan enable; low forces idle.
- `i_load`  in  1: one-cycle strobe; captures `i_bcd`, `i_dp` and `i_blank` into the pending buffer.
- `i_bcd`  in  4*`NUM_DIGITS`: digit k is `i_bcd[4k+3:4k]`.
- `i_dp`  in  `NUM_DIGITS`: decimal point for digit k.
- `i_blank`  in  `NUM_DIGITS`: force digit k segments and dp off.
- `o_led`  out  7: segments {a,b,c,d,e,f,g}, bit 6 = a, 1 = lit; registered.
- `o_dp`  out  1: decimal point, 1 = lit; registered.
- `o_digit_sel`  out  `NUM_DIGITS`: one-hot digit enable, 1 = active; registered.
- `o_frame_done`  out  1: one-cycle pulse at the end of each full scan; registered.

## Operation
- **Buffers**
  - Pending buffer: written on any edge with `i_load`=1, in any state.
  - Active buffer: copied from pending on every frame-start edge.
  - Reset value of both: all digits 4'hF, `i_dp` and `i_blank` fields 0. After reset the display is blank.
- **Decode** (digit value → `o_led`, a..g)
  - 0→1111110, 1→0110000, 2→1101101, 3→1111001, 4→0110011
  - 5→1011011, 6→1011111, 7→1110000, 8→1111111, 9→1111011
  - 10–15→0000000
- **States**
  - IDLE: all outputs 0; slot counter = 0, digit index = 0.
  - GUARD: `o_led`, `o_dp` and `o_digit_sel` are 0.
  - DRIVE: `o_digit_sel` = bit k only; `o_led` = decode(active digit k); `o_dp` = active dp[k].
  - In DRIVE, if active blank[k]=1 then `o_led`=0 and `o_dp`=0, but `o_digit_sel`[k] stays 1.
- **Transitions**
  - IDLE→GUARD on the first edge with `i_reset`=0 and `i_enable`=1. Call this edge E0; it is a frame-start edge.
  - With `GUARD`=0, GUARD is skipped entirely.
  - GUARD→DRIVE after `GUARD` cycles.
  - DRIVE→GUARD of the next digit after `REFRESH_DIV`-`GUARD` cycles.
  - After the last digit (k = `NUM_DIGITS`-1), wrap to digit 0. The edge that starts the digit-0 slot is a frame-start edge.
  - Any state→IDLE on an edge sampling `i_enable`=0. Outputs are 0 in the following cycle; the buffers are kept.
- **Priority**: `i_reset` > `i_enable`=0 > scan.
  - `i_load` on a frame-start edge updates pending only. The new data appears in the following frame.

## Timing
- Cycle n means the n-th clock period after E0, with n starting at 0.
- Slot s covers cycles s·`REFRESH_DIV` … (s+1)·`REFRESH_DIV`-1. Digit k = s mod `NUM_DIGITS`.
  - Guard window: the first `GUARD` cycles of the slot.
  - Drive window: the remaining `REFRESH_DIV`-`GUARD` cycles.
- `o_frame_done`=1 exactly in the last cycle of each slot where k = `NUM_DIGITS`-1.
- `o_digit_sel` is never multi-hot. It is never nonzero during a guard window.
- Reset mid-scan: in the cycle after the reset edge, all outputs are 0, both buffers are back to reset values, and the block is in IDLE. If `i_enable` is still 1 once `i_reset` drops, the next edge is E0.
- Data latency: `i_load` at edge L becomes visible at the first frame-start edge strictly after L.

## Test plan
Bench parameters: `NUM_DIGITS`=6, `REFRESH_DIV`=8, `GUARD`=2.

- **Reset and blank.** Release reset, set `i_enable`=1, no load.
  - Cycles 0–47: `o_led`=0, `o_dp`=0.
  - `o_digit_sel`=000001 in cycles 2–7, 000010 in cycles 10–15, and so on.
  - `o_frame_done` pulses at cycle 47.
- **Basic scan.** Load `i_bcd`=24'h123456 while idle, then enable.
  - Cycles 2–7: `o_led`=1011111 (digit 6).
  - Cycles 42–47: `o_led`=0110000 (digit 1), `o_digit_sel`=100000.
  - Decoding `o_led` with the bench checker yields 6,5,4,3,2,1.
- **Double buffering.** While running, load 24'h999999 at cycle 20.
  - Frame 0 (cycles 0–47) still shows 123456.
  - From cycle 50 on, `o_led`=1111011 for every digit.
- **Masks.** Load `i_bcd`=24'hFA0780, `i_dp`=000100, `i_blank`=000010.
  - Digit 0: `o_led`=1111110.
  - Digit 1: `o_led`=0 with `o_digit_sel`=000010.
  - Digit 2: `o_led`=1110000, `o_dp`=1.
  - Digits 3–5: `o_led` = 1111110, 0000000, 0000000.
- **Enable drop.** Drop `i_enable` at cycle 13, raise it at cycle 30.
  - Outputs are 0 from cycle 14.
  - The scan restarts at digit 0, with a guard window first.
- **Reset mid-operation.** Assert `i_reset` at cycle 25 for one edge while `i_enable` stays 1.
  - Outputs are 0 on the next cycle.
  - The following frame is fully blank (buffers are reset), and its slot timing restarts from a new E0.
